// File: rtl/snitch_data_mem_pd_pkg.sv
// Shared types for the power-managed banked TCDM data memory.
package snitch_data_mem_pd_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SLEEP  = 2'd2,
        WAKE   = 2'd3
    } pd_state_e;

    typedef logic [7:0] sram_cfg_t;

    typedef struct packed {
        sram_cfg_t tcdm;
    } sram_cfgs_t;

    // Counter/address width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snitch_data_mem_pd_ctrl.sv
// Per power group controller: sleep FSM, idle/wake counters and read in-flight tracking.
module snitch_data_mem_pd_ctrl
    import snitch_data_mem_pd_pkg::*;
#(
    parameter int unsigned ReadLatency     = 1,
    parameter int unsigned WakeCycles      = 8,
    parameter int unsigned IdleSleepCycles = 0
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_sleep_req,
    input  logic      i_any_cs,
    input  logic      i_rd_gnt,
    output pd_state_e o_state,
    output logic      o_ret
);

    localparam int unsigned IdleWidth = clog2_min1(IdleSleepCycles + 1);
    localparam int unsigned WakeWidth = clog2_min1(WakeCycles);
    localparam logic [IdleWidth-1:0] IdleMax  = IdleWidth'(IdleSleepCycles);
    localparam logic [IdleWidth-1:0] IdleLast = IdleWidth'(IdleSleepCycles - 1);
    localparam logic [WakeWidth-1:0] WakeLoad = WakeWidth'(WakeCycles - 1);

    logic [IdleWidth-1:0] r_idle;
    logic [WakeWidth-1:0] r_wake;
    logic                 w_inflight;
    logic                 w_idle_hit;

    // A read is pending until its rvalid cycle; the rvalid cycle itself may end the drain.
    if (ReadLatency > 1) begin : g_track
        logic [ReadLatency-2:0] r_rd_pipe;
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_rd_pipe <= '0;
            end else begin
                r_rd_pipe <= (r_rd_pipe << 1) | (ReadLatency-1)'(i_rd_gnt);
            end
        end
        assign w_inflight = |r_rd_pipe;
    end else begin : g_no_track
        logic w_unused_rd;
        assign w_unused_rd = i_rd_gnt;
        assign w_inflight  = 1'b0;
    end

    // Fires on the idle cycle that would bring the count to IdleSleepCycles.
    assign w_idle_hit = (IdleSleepCycles != 0) && !i_any_cs && (r_idle == IdleLast);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_state <= ACTIVE;
            o_ret   <= 1'b0;
            r_idle  <= '0;
            r_wake  <= '0;
        end else begin
            case (o_state)
                ACTIVE: begin
                    if (i_sleep_req || w_idle_hit) begin
                        o_state <= DRAIN;
                        r_idle  <= '0;
                    end else if (i_any_cs) begin
                        r_idle <= '0;
                    end else if (r_idle != IdleMax) begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!w_inflight) begin
                        o_state <= SLEEP;
                        o_ret   <= 1'b1;
                    end
                end
                SLEEP: begin
                    if (!i_sleep_req && i_any_cs) begin
                        o_state <= WAKE;
                        o_ret   <= 1'b0;
                        r_wake  <= WakeLoad;
                    end
                end
                WAKE: begin
                    if (r_wake == '0) begin
                        o_state <= ACTIVE;
                    end else begin
                        r_wake <= r_wake - 1'b1;
                    end
                end
                default: o_state <= ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/tc_sram_impl.sv
// Behavioural byte-enabled SRAM macro with registered read data.
module tc_sram_impl
    import snitch_data_mem_pd_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 1,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = clog2_min1(NumWords),
    parameter int unsigned BeWidth   = DataWidth / ByteWidth
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  sram_cfg_t                            impl_i,
    input  logic [NumPorts-1:0]                  req_i,
    input  logic [NumPorts-1:0]                  we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

    logic [DataWidth-1:0]                        r_mem [NumWords];
    logic [Latency-1:0][NumPorts-1:0][DataWidth-1:0] r_rdata;
    logic                                        w_unused_impl;

    // Macro tuning bits have no behavioural effect.
    assign w_unused_impl = ^impl_i;

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (req_i[p] && we_i[p]) begin
                for (int b = 0; b < int'(BeWidth); b++) begin
                    if (be_i[p][b]) begin
                        r_mem[addr_i[p]][b*ByteWidth +: ByteWidth] <= wdata_i[p][b*ByteWidth +: ByteWidth];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                if (req_i[p] && !we_i[p]) begin
                    r_rdata[0][p] <= r_mem[addr_i[p]];
                end
            end
            for (int s = 1; s < int'(Latency); s++) begin
                r_rdata[s] <= r_rdata[s-1];
            end
        end
    end

    assign rdata_o = r_rdata[Latency-1];

endmodule

// File: rtl/snitch_data_mem_pd.sv
// Banked TCDM data memory with per-group retention sleep and a configurable read pipeline.
module snitch_data_mem_pd
    import snitch_data_mem_pd_pkg::*;
#(
    parameter int unsigned TCDMDepth       = 1024,
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned NumTotalBanks   = 32,
    parameter int unsigned NumPowerGroups  = 4,
    parameter int unsigned ReadLatency     = 1,
    parameter int unsigned WakeCycles      = 8,
    parameter int unsigned IdleSleepCycles = 0,
    localparam int unsigned AddrWidth      = clog2_min1(TCDMDepth),
    localparam int unsigned StrbWidth      = NarrowDataWidth / 8
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  sram_cfgs_t                                       sram_cfgs_i,
    input  logic [NumTotalBanks-1:0]                         mem_cs_i,
    input  logic [NumTotalBanks-1:0][AddrWidth-1:0]          mem_add_i,
    input  logic [NumTotalBanks-1:0]                         mem_wen_i,
    input  logic [NumTotalBanks-1:0][StrbWidth-1:0]          mem_be_i,
    input  logic [NumTotalBanks-1:0][NarrowDataWidth-1:0]    mem_wdata_i,
    output logic [NumTotalBanks-1:0]                         mem_gnt_o,
    output logic [NumTotalBanks-1:0]                         mem_rvalid_o,
    output logic [NumTotalBanks-1:0][NarrowDataWidth-1:0]    mem_rdata_o,
    input  logic [NumPowerGroups-1:0]                        sleep_req_i,
    output logic [NumPowerGroups-1:0][1:0]                   group_state_o,
    output logic [NumPowerGroups-1:0]                        sram_ret_o
);

    localparam int unsigned BanksPerGroup = NumTotalBanks / NumPowerGroups;

    pd_state_e                                      w_state [NumPowerGroups];
    logic [NumTotalBanks-1:0]                       w_rd_gnt;
    logic [NumTotalBanks-1:0][NarrowDataWidth-1:0]  w_sram_rdata;

    for (genvar g = 0; g < NumPowerGroups; g++) begin : g_group
        snitch_data_mem_pd_ctrl #(
            .ReadLatency     (ReadLatency),
            .WakeCycles      (WakeCycles),
            .IdleSleepCycles (IdleSleepCycles)
        ) i_ctrl (
            .i_clk       (clk_i),
            .i_rst_n     (rst_ni),
            .i_sleep_req (sleep_req_i[g]),
            .i_any_cs    (|mem_cs_i[g*BanksPerGroup +: BanksPerGroup]),
            .i_rd_gnt    (|w_rd_gnt[g*BanksPerGroup +: BanksPerGroup]),
            .o_state     (w_state[g]),
            .o_ret       (sram_ret_o[g])
        );
        assign group_state_o[g] = w_state[g];
    end

    for (genvar b = 0; b < NumTotalBanks; b++) begin : g_bank
        localparam int unsigned Grp = b / BanksPerGroup;

        logic [ReadLatency-1:0] r_vld;

        // Only an ACTIVE group hands out grants; the macro sees nothing otherwise.
        assign mem_gnt_o[b] = mem_cs_i[b] && (w_state[Grp] == ACTIVE);
        assign w_rd_gnt[b]  = mem_gnt_o[b] && !mem_wen_i[b];

        tc_sram_impl #(
            .NumWords  (TCDMDepth),
            .DataWidth (NarrowDataWidth),
            .ByteWidth (8),
            .NumPorts  (1),
            .Latency   (1)
        ) i_sram (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .impl_i  (sram_cfgs_i.tcdm),
            .req_i   (mem_gnt_o[b]),
            .we_i    (mem_wen_i[b]),
            .addr_i  (mem_add_i[b]),
            .wdata_i (mem_wdata_i[b]),
            .be_i    (mem_be_i[b]),
            .rdata_o (w_sram_rdata[b])
        );

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_vld <= '0;
            end else begin
                r_vld <= (r_vld << 1) | ReadLatency'(w_rd_gnt[b]);
            end
        end

        assign mem_rvalid_o[b] = r_vld[ReadLatency-1];

        if (ReadLatency > 1) begin : g_dly
            logic [ReadLatency-2:0][NarrowDataWidth-1:0] r_dly;
            // Each stage advances only with its own read, so idle cycles hold the last data.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_dly <= '0;
                end else begin
                    if (r_vld[0]) begin
                        r_dly[0] <= w_sram_rdata[b];
                    end
                    for (int s = 1; s < int'(ReadLatency) - 1; s++) begin
                        if (r_vld[s]) begin
                            r_dly[s] <= r_dly[s-1];
                        end
                    end
                end
            end
            assign mem_rdata_o[b] = r_dly[ReadLatency-2];
        end else begin : g_direct
            assign mem_rdata_o[b] = w_sram_rdata[b];
        end
    end

endmodule

// File: tb/tb_snitch_data_mem_pd.sv
// Directed bench: dut_a (ReadLatency 2, no auto-sleep) and dut_b (ReadLatency 3, IdleSleepCycles 4).
module tb_snitch_data_mem_pd;
    import snitch_data_mem_pd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lat;

    sram_cfgs_t cfg;

    logic                  a_rst_n, b_rst_n;
    logic [31:0]           a_cs, a_wen, a_gnt, a_rvalid;
    logic [31:0][3:0]      a_add;
    logic [31:0][7:0]      a_be;
    logic [31:0][63:0]     a_wdata, a_rdata;
    logic [3:0]            a_sleep, a_ret;
    logic [3:0][1:0]       a_state;
    logic [31:0]           b_cs, b_wen, b_gnt, b_rvalid;
    logic [31:0][3:0]      b_add;
    logic [31:0][7:0]      b_be;
    logic [31:0][63:0]     b_wdata, b_rdata;
    logic [3:0]            b_sleep, b_ret;
    logic [3:0][1:0]       b_state;

    snitch_data_mem_pd #(
        .TCDMDepth(16), .NarrowDataWidth(64), .NumTotalBanks(32), .NumPowerGroups(4),
        .ReadLatency(2), .WakeCycles(8), .IdleSleepCycles(0)
    ) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .sram_cfgs_i(cfg),
        .mem_cs_i(a_cs), .mem_add_i(a_add), .mem_wen_i(a_wen), .mem_be_i(a_be),
        .mem_wdata_i(a_wdata), .mem_gnt_o(a_gnt), .mem_rvalid_o(a_rvalid),
        .mem_rdata_o(a_rdata), .sleep_req_i(a_sleep), .group_state_o(a_state),
        .sram_ret_o(a_ret)
    );

    snitch_data_mem_pd #(
        .TCDMDepth(16), .NarrowDataWidth(64), .NumTotalBanks(32), .NumPowerGroups(4),
        .ReadLatency(3), .WakeCycles(2), .IdleSleepCycles(4)
    ) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .sram_cfgs_i(cfg),
        .mem_cs_i(b_cs), .mem_add_i(b_add), .mem_wen_i(b_wen), .mem_be_i(b_be),
        .mem_wdata_i(b_wdata), .mem_gnt_o(b_gnt), .mem_rvalid_o(b_rvalid),
        .mem_rdata_o(b_rdata), .sleep_req_i(b_sleep), .group_state_o(b_state),
        .sram_ret_o(b_ret)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg = '0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_cs = '0; a_wen = '0; a_add = '0; a_be = '0; a_wdata = '0; a_sleep = '0;
        b_cs = '0; b_wen = '0; b_add = '0; b_be = '0; b_wdata = '0; b_sleep = '0;
        step(); step();

        // dut_a reset values
        a_rst_n = 1'b1;
        #1;
        chk("a_rst_state", 64'(a_state), 64'h0);
        chk("a_rst_ret", 64'(a_ret), 64'h0);
        chk("a_rst_rvalid", 64'(a_rvalid), 64'h0);
        chk("a_rst_rdata0", a_rdata[0], 64'h0);

        // Write bank 0 addr 5 and bank 8 addr 3, then read bank 0 back
        a_cs[0] = 1'b1; a_wen[0] = 1'b1; a_add[0] = 4'd5; a_be[0] = 8'hFF;
        a_wdata[0] = 64'hDEADBEEF_CAFEF00D;
        a_cs[8] = 1'b1; a_wen[8] = 1'b1; a_add[8] = 4'd3; a_be[8] = 8'hFF;
        a_wdata[8] = 64'h1234;
        #1;
        chk("a_wr_gnt0", 64'(a_gnt[0]), 64'h1);
        chk("a_wr_gnt8", 64'(a_gnt[8]), 64'h1);
        step();
        a_wen[0] = 1'b0; a_cs[8] = 1'b0;
        #1;
        chk("a_rd_gnt0", 64'(a_gnt[0]), 64'h1);
        step();
        a_cs[0] = 1'b0;
        #1;
        chk("a_rvalid_early", 64'(a_rvalid), 64'h0);
        step(); #1;
        chk("a_rvalid_lat2", 64'(a_rvalid), 64'h1);
        chk("a_rdata_b0", a_rdata[0], 64'hDEADBEEF_CAFEF00D);
        step(); #1;
        chk("a_rvalid_once", 64'(a_rvalid), 64'h0);

        // Explicit sleep of group 1 with no traffic
        a_sleep[1] = 1'b1;
        #1;
        chk("a_g1_active_t", 64'(a_state[1]), 64'h0);
        step(); #1;
        chk("a_g1_drain", 64'(a_state[1]), 64'h1);
        step(); #1;
        chk("a_g1_sleep", 64'(a_state[1]), 64'h2);
        chk("a_ret", 64'(a_ret), 64'h2);
        a_cs[8] = 1'b1; a_wen[8] = 1'b0; a_add[8] = 4'd3;
        #1;
        chk("a_sleep_nognt", 64'(a_gnt[8]), 64'h0);
        step(); #1;
        chk("a_sleep_nognt2", 64'(a_gnt[8]), 64'h0);
        chk("a_g1_still_sleep", 64'(a_state[1]), 64'h2);

        // Wake on access: grant 1+WakeCycles cycles after cs, data retained
        a_sleep[1] = 1'b0;
        #1;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (a_gnt[8]) begin
                lat = k;
                break;
            end
            step();
        end
        chk("a_wake_gnt_lat", 64'(lat), 64'd9);
        chk("a_g1_active", 64'(a_state[1]), 64'h0);
        chk("a_ret_clear", 64'(a_ret), 64'h0);
        step();
        a_cs[8] = 1'b0;
        #1;
        chk("a_wake_rvalid_early", 64'(a_rvalid), 64'h0);
        step(); #1;
        chk("a_wake_rvalid", 64'(a_rvalid), 64'h100);
        chk("a_retained", a_rdata[8], 64'h1234);

        // Reset during WAKE with a read in flight on bank 0
        a_sleep[1] = 1'b1;
        step(); step();
        a_sleep[1] = 1'b0; a_cs[8] = 1'b1;
        step(); #1;
        chk("a_g1_wake", 64'(a_state[1]), 64'h3);
        a_cs[0] = 1'b1; a_wen[0] = 1'b0; a_add[0] = 4'd5;
        #1;
        chk("a_inflight_gnt", 64'(a_gnt[0]), 64'h1);
        step();
        a_cs = '0; a_rst_n = 1'b0;
        step();
        a_rst_n = 1'b1;
        #1;
        chk("a_mid_rst_state", 64'(a_state), 64'h0);
        chk("a_mid_rst_rvalid", 64'(a_rvalid), 64'h0);
        chk("a_mid_rst_ret", 64'(a_ret), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("a_no_spurious_rvalid", 64'(a_rvalid), 64'h0);
        end

        // dut_b: read granted together with sleep request, ReadLatency 3
        b_rst_n = 1'b1;
        b_cs[2] = 1'b1; b_wen[2] = 1'b1; b_add[2] = 4'd7; b_be[2] = 8'hFF;
        b_wdata[2] = 64'h55AA;
        #1;
        chk("b_wr_gnt", 64'(b_gnt[2]), 64'h1);
        step();
        b_wen[2] = 1'b0; b_sleep[0] = 1'b1;
        #1;
        chk("b_rd_gnt_with_sleep", 64'(b_gnt[2]), 64'h1);
        step();
        b_cs[2] = 1'b0;
        #1;
        chk("b_g0_drain", 64'(b_state[0]), 64'h1);
        chk("b_rvalid_c2", 64'(b_rvalid), 64'h0);
        step(); #1;
        chk("b_drain_hold", 64'(b_state[0]), 64'h1);
        chk("b_rvalid_c3", 64'(b_rvalid), 64'h0);
        step(); #1;
        chk("b_rvalid_lat3", 64'(b_rvalid), 64'h4);
        chk("b_rdata", b_rdata[2], 64'h55AA);
        chk("b_drain_at_rvalid", 64'(b_state[0]), 64'h1);
        step(); #1;
        chk("b_g0_sleep", 64'(b_state[0]), 64'h2);
        chk("b_ret0", 64'(b_ret[0]), 64'h1);

        // Wake group 0 with a read, then idle auto-sleep behaviour
        b_sleep[0] = 1'b0; b_cs[2] = 1'b1;
        #1;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (b_gnt[2]) begin
                lat = k;
                break;
            end
            step();
        end
        chk("b_wake_gnt_lat", 64'(lat), 64'd3);
        step();
        b_cs[2] = 1'b0;
        step(); step(); #1;
        chk("b_wake_rvalid", 64'(b_rvalid), 64'h4);
        chk("b_wake_rdata", b_rdata[2], 64'h55AA);
        step();
        b_cs[1] = 1'b1; b_wen[1] = 1'b1; b_add[1] = 4'd0; b_be[1] = 8'hFF; b_wdata[1] = 64'h1;
        #1;
        chk("b_idle3_gnt", 64'(b_gnt[1]), 64'h1);
        chk("b_idle3_active", 64'(b_state[0]), 64'h0);
        step();
        b_cs[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("b_idle_no_sleep", 64'(b_state[0]), 64'h0);
            step();
        end
        #1;
        chk("b_idle_drain", 64'(b_state[0]), 64'h1);
        step(); #1;
        chk("b_idle_sleep", 64'(b_state[0]), 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
